// File: rtl/axis_uart_bridge_pkg.sv
// axis_uart_bridge_pkg: types, line levels and timing helper shared by the tx and rx sides.
// Optional feature macro: AXIS_UART_BRIDGE_TX_PARITY_EN (adds the PARITY state).
package axis_uart_bridge_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef AXIS_UART_BRIDGE_TX_PARITY_EN
        PARITY,
`endif
        STOP
    } tx_state_t;

    localparam logic UART_IDLE_LEVEL = 1'b1;
    localparam logic START_LEVEL     = 1'b0;

    function automatic int bit_period(input int freq_hz, input int uart_speed);
        return freq_hz / uart_speed;
    endfunction

endpackage

// File: rtl/axis_uart_baud_gen.sv
// axis_uart_baud_gen: one-cycle tick every BIT_PERIOD clocks, restartable.
// Ports:
//   clk       - clock, rising edge
//   reset     - asynchronous active-high reset
//   i_restart - synchronous restart; holds the count at 0 and masks the tick
//   o_tick    - high on the last cycle of each bit period
module axis_uart_baud_gen #(
    parameter int BIT_PERIOD = 868
)(
    input  logic clk,
    input  logic reset,
    input  logic i_restart,
    output logic o_tick
);

    if (BIT_PERIOD < 2 || BIT_PERIOD > 65535) begin : g_bad_period
        $error("BIT_PERIOD must lie in 2..65535");
    end

    logic [15:0] r_cnt;

    assign o_tick = !i_restart && (r_cnt == 16'(BIT_PERIOD - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_cnt <= '0;
        else if (i_restart || o_tick)
            r_cnt <= '0;
        else
            r_cnt <= r_cnt + 16'd1;
    end

endmodule

// File: rtl/axis_uart_bridge_tx.sv
// axis_uart_bridge_tx: serializes one AXI-Stream word, byte 0 first, as back-to-back UART frames.
// Optional feature macro: AXIS_UART_BRIDGE_TX_PARITY_EN (even parity symbol after bit 7).
// Ports:
//   clk           - clock, rising edge
//   reset         - asynchronous active-high reset
//   S_AXIS_TDATA  - word to serialize (N_BYTES*8 bits)
//   S_AXIS_TVALID - word valid
//   S_AXIS_TREADY - high only in IDLE; a word is accepted on TVALID & TREADY
//   UART_TX       - serial line, idle high
//   BUSY          - high from acceptance until the last stop bit completes
module axis_uart_bridge_tx
    import axis_uart_bridge_pkg::*;
#(
    parameter int UART_SPEED = 115200,
    parameter int FREQ_HZ    = 100000000,
    parameter int N_BYTES    = 32,
    parameter int STOP_BITS  = 1,
    localparam int DATA_WIDTH = N_BYTES * 8
)(
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] S_AXIS_TDATA,
    input  logic                  S_AXIS_TVALID,
    output logic                  S_AXIS_TREADY,
    output logic                  UART_TX,
    output logic                  BUSY
);

    localparam int BIT_PERIOD = bit_period(FREQ_HZ, UART_SPEED);
    localparam int BW         = N_BYTES > 1 ? $clog2(N_BYTES) : 1;

    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
        $error("STOP_BITS must be 1 or 2");
    end

    tx_state_t             r_state;
    logic [DATA_WIDTH-1:0] r_shift;
    logic [2:0]            r_bit;
    logic [BW-1:0]         r_byte;
    logic                  r_tx;
    logic                  r_ready;
    logic                  r_busy;
    logic                  w_tick;
`ifdef AXIS_UART_BRIDGE_TX_PARITY_EN
    logic                  r_par;
`endif

    assign S_AXIS_TREADY = r_ready;
    assign UART_TX       = r_tx;
    assign BUSY          = r_busy;

    // Holding the counter in IDLE and only leaving other states on a tick means
    // every state is entered with the baud count at 0.
    axis_uart_baud_gen #(
        .BIT_PERIOD(BIT_PERIOD)
    ) u_baud (
        .clk      (clk),
        .reset    (reset),
        .i_restart(r_state == IDLE),
        .o_tick   (w_tick)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_shift <= '0;
            r_bit   <= '0;
            r_byte  <= '0;
            r_tx    <= UART_IDLE_LEVEL;
            r_ready <= 1'b0;
            r_busy  <= 1'b0;
`ifdef AXIS_UART_BRIDGE_TX_PARITY_EN
            r_par   <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    r_tx <= UART_IDLE_LEVEL;
                    if (S_AXIS_TVALID && r_ready) begin
                        r_shift <= S_AXIS_TDATA;
                        r_byte  <= '0;
                        r_bit   <= '0;
                        r_state <= START;
                        r_tx    <= START_LEVEL;
                        r_ready <= 1'b0;
                        r_busy  <= 1'b1;
                    end else begin
                        r_ready <= 1'b1;
                    end
                end
                START: if (w_tick) begin
                    r_state <= DATA;
                    r_bit   <= '0;
                    r_tx    <= r_shift[0];
`ifdef AXIS_UART_BRIDGE_TX_PARITY_EN
                    r_par   <= ^r_shift[7:0];
`endif
                end
                // The whole word shifts right one bit per data symbol, so after
                // eight symbols the next byte sits in the low bits.
                DATA: if (w_tick) begin
                    r_shift <= r_shift >> 1;
                    if (r_bit == 3'd7) begin
                        r_bit   <= '0;
`ifdef AXIS_UART_BRIDGE_TX_PARITY_EN
                        r_state <= PARITY;
                        r_tx    <= r_par;
`else
                        r_state <= STOP;
                        r_tx    <= UART_IDLE_LEVEL;
`endif
                    end else begin
                        r_bit <= r_bit + 3'd1;
                        r_tx  <= r_shift[1];
                    end
                end
`ifdef AXIS_UART_BRIDGE_TX_PARITY_EN
                PARITY: if (w_tick) begin
                    r_state <= STOP;
                    r_tx    <= UART_IDLE_LEVEL;
                end
`endif
                // r_bit counts stop symbols here; the line simply stays high.
                STOP: if (w_tick) begin
                    if (r_bit == 3'(STOP_BITS - 1)) begin
                        r_bit <= '0;
                        if (r_byte == BW'(N_BYTES - 1)) begin
                            r_state <= IDLE;
                            r_ready <= 1'b1;
                            r_busy  <= 1'b0;
                        end else begin
                            r_byte  <= r_byte + BW'(1);
                            r_state <= START;
                            r_tx    <= START_LEVEL;
                        end
                    end else begin
                        r_bit <= r_bit + 3'd1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axis_uart_bridge_tx.sv
// tb_axis_uart_bridge_tx: directed checks of the AXI-Stream to UART serializer.
module tb_axis_uart_bridge_tx;

    localparam int BP = 10;
`ifdef AXIS_UART_BRIDGE_TX_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] data = '0;
    logic        valid1 = 1'b0;
    logic        valid2 = 1'b0;
    logic        use2 = 1'b0;
    logic        rdy1, rdy2, tx1, tx2, busy1, busy2;
    logic        rdy_m, tx_m, busy_m;
    int          n_checks = 0;
    int          n_pass = 0;

    always #5 clk = ~clk;

    assign rdy_m  = use2 ? rdy2  : rdy1;
    assign tx_m   = use2 ? tx2   : tx1;
    assign busy_m = use2 ? busy2 : busy1;

    axis_uart_bridge_tx #(
        .UART_SPEED(100000), .FREQ_HZ(1000000), .N_BYTES(2), .STOP_BITS(1)
    ) u_dut (
        .clk(clk), .reset(reset), .S_AXIS_TDATA(data), .S_AXIS_TVALID(valid1),
        .S_AXIS_TREADY(rdy1), .UART_TX(tx1), .BUSY(busy1)
    );

    axis_uart_bridge_tx #(
        .UART_SPEED(100000), .FREQ_HZ(1000000), .N_BYTES(2), .STOP_BITS(2)
    ) u_dut2 (
        .clk(clk), .reset(reset), .S_AXIS_TDATA(data), .S_AXIS_TVALID(valid2),
        .S_AXIS_TREADY(rdy2), .UART_TX(tx2), .BUSY(busy2)
    );

    function automatic logic sym_val(input logic [15:0] w, input int s, input int sb);
        int spb, b, k;
        logic [7:0] by;
        spb = 9 + PAR + sb;
        b = s / spb;
        k = s % spb;
        by = w[8*b +: 8];
        if (k == 0) return 1'b0;
        if (k <= 8) return by[k-1];
        if (PAR == 1 && k == 9) return ^by;
        return 1'b1;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [15:0] w, input logic second);
        n_checks++;
        if (rdy_m === 1'b1) n_pass++;
        else $display("FAIL send_ready: tready=%b expected 1", rdy_m);
        data = w;
        if (second) valid2 = 1'b1; else valid1 = 1'b1;
        step();
        valid1 = 1'b0;
        valid2 = 1'b0;
    endtask

    // Called at the first sample after the accepting edge; walks the whole frame.
    task automatic check_frame(input string name, input logic [15:0] w, input int sb);
        int nsym, bad, rdy_bad, busy_bad;
        logic exp, got;
        nsym = 2 * (9 + PAR + sb);
        rdy_bad = 0;
        busy_bad = 0;
        for (int s = 0; s < nsym; s++) begin
            exp = sym_val(w, s, sb);
            got = exp;
            bad = 0;
            for (int c = 0; c < BP; c++) begin
                if (tx_m !== exp) begin bad++; got = tx_m; end
                if (rdy_m !== 1'b0) rdy_bad++;
                if (busy_m !== 1'b1) busy_bad++;
                step();
            end
            n_checks++;
            if (bad == 0) n_pass++;
            else $display("FAIL %s symbol %0d: line=%b in %0d cycles, expected %b", name, s, got, bad, exp);
        end
        n_checks++;
        if (rdy_bad == 0) n_pass++;
        else $display("FAIL %s tready_low: high in %0d frame cycles, expected 0", name, rdy_bad);
        n_checks++;
        if (busy_bad == 0) n_pass++;
        else $display("FAIL %s busy_high: low in %0d frame cycles, expected 0", name, busy_bad);
        n_checks++;
        if (rdy_m === 1'b1 && busy_m === 1'b0 && tx_m === 1'b1) n_pass++;
        else $display("FAIL %s end_idle: tready=%b busy=%b line=%b, expected 1 0 1", name, rdy_m, busy_m, tx_m);
    endtask

    task automatic test_reset();
        #2 reset = 1'b1;
        step();
        step();
        n_checks++;
        if (tx1 === 1'b1 && rdy1 === 1'b0 && busy1 === 1'b0) n_pass++;
        else $display("FAIL reset_state: line=%b tready=%b busy=%b, expected 1 0 0", tx1, rdy1, busy1);
        reset = 1'b0;
        #1;
        n_checks++;
        if (rdy1 === 1'b0) n_pass++;
        else $display("FAIL reset_release_ready: tready=%b before edge, expected 0", rdy1);
        step();
        n_checks++;
        if (rdy1 === 1'b1 && rdy2 === 1'b1) n_pass++;
        else $display("FAIL ready_after_reset: tready=%b/%b, expected 1/1", rdy1, rdy2);
    endtask

    task automatic test_single_word();
        use2 = 1'b0;
        send(16'hA55A, 1'b0);
        check_frame("word_a55a", 16'hA55A, 1);
        step();
        send(16'h0307, 1'b0);
        check_frame("word_0307", 16'h0307, 1);
    endtask

    task automatic test_back_to_back();
        use2 = 1'b0;
        step();
        data = 16'h0001;
        valid1 = 1'b1;
        step();
        data = 16'hFFFF;
        check_frame("b2b_first", 16'h0001, 1);
        step();
        valid1 = 1'b0;
        check_frame("b2b_second", 16'hFFFF, 1);
    endtask

    task automatic test_reset_mid_frame();
        use2 = 1'b0;
        step();
        send(16'h0000, 1'b0);
        for (int i = 0; i < 55; i++) step();
        n_checks++;
        if (tx1 === 1'b0) n_pass++;
        else $display("FAIL midframe_line: line=%b at cycle 55, expected 0", tx1);
        reset = 1'b1;
        #1;
        n_checks++;
        if (tx1 === 1'b1 && busy1 === 1'b0 && rdy1 === 1'b0) n_pass++;
        else $display("FAIL reset_immediate: line=%b busy=%b tready=%b, expected 1 0 0", tx1, busy1, rdy1);
        step();
        reset = 1'b0;
        #1;
        n_checks++;
        if (tx1 === 1'b1 && rdy1 === 1'b0) n_pass++;
        else $display("FAIL reset_hold: line=%b tready=%b, expected 1 0", tx1, rdy1);
        step();
        n_checks++;
        if (rdy1 === 1'b1) n_pass++;
        else $display("FAIL ready_after_abort: tready=%b, expected 1", rdy1);
        send(16'h00FF, 1'b0);
        check_frame("after_abort_00ff", 16'h00FF, 1);
    endtask

    task automatic test_stop_bits();
        use2 = 1'b1;
        step();
        send(16'h8000, 1'b1);
        check_frame("stop2_8000", 16'h8000, 2);
        use2 = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single_word();
        test_back_to_back();
        test_reset_mid_frame();
        test_stop_bits();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
